apb_ram_bridge: RTL and testbench
=================================

# apb_ram_bridge

APB completer that turns APB read/write transfers into single-cycle accesses on the 2048-word byte-writable RAM port (CLK/EN/WE[3:0]/Di/Do/A). It sits between the APB interconnect and the data RAM, so the RISC-V subsystem's APB masters reach the RAM through a fixed one-wait-state handshake. The bridge is the only block that drives the RAM's EN, WE, Di and A; it owns address decode, byte-strobe mapping and error signalling.

## Interface
- ADDR_WIDTH, 32, APB byte-address width; RAM A port width
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
- DEPTH_WORDS, 2048, RAM depth in words; valid word index 0..DEPTH_WORDS-1
- CLK  in  1  single clock for APB and RAM
- RST  in  1  synchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  4  write byte strobes; ignored on reads
- PRDATA  out  DATA_WIDTH  read data; valid only while PREADY=1 on a read
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error response, valid only while PREADY=1
- ram_en  out  1  to RAM EN
- ram_we  out  4  to RAM WE
- ram_di  out  DATA_WIDTH  to RAM Di
- ram_a  out  ADDR_WIDTH  to RAM A (word index, zero-extended)
- ram_do  in  DATA_WIDTH  from RAM Do (combinational read data)

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: on PSEL=1 & PENABLE=0, latch PADDR, PWRITE, PWDATA, PSTRB; compute err = (PADDR[1:0]!=0) | (PADDR>>2 >= DEPTH_WORDS); go ISSUE. PSEL=1 & PENABLE=1 in IDLE (protocol violation): ignored, stay IDLE.
- ISSUE: if !err: ram_a = latched PADDR>>2; write: ram_en=1, ram_we=latched PSTRB, ram_di=PWDATA; read: ram_en=1, ram_we=0, capture ram_do into read register at end of cycle. Write with PSTRB=0: ram_en=0, completes OKAY. If err: ram_en=0, ram_we=0. Go RESP.
- RESP: PREADY=1; PSLVERR=err; PRDATA=captured data on OKAY read, 0 on writes and errors. Go IDLE.
- PSEL deasserted while in ISSUE or RESP: abort to IDLE at next edge, PREADY not asserted further; a write already issued in ISSUE stays committed.
- Word index truncation: upper PADDR bits beyond the range check never alias; any index >= DEPTH_WORDS is an error.

## Timing
- Reset (RST=1 at edge): state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0, ram_en=0, ram_we=0, ram_di=0, ram_a=0, read register=0. RST mid-transfer discards it with no RAM access after the reset edge.
- All outputs registered or decoded from state only; none depend combinationally on APB inputs.
- Setup at cycle T, RAM access in T+1 (ram_en high exactly one cycle), PREADY=1 in T+2, transfer done end of T+2. Fixed latency: one wait state; every transfer takes 3 cycles.
- Back-to-back: next setup phase earliest at T+3; ram_en low in T+2 and T+3.
- ram_en/ram_we are high only in ISSUE; never high in IDLE or RESP.

## Structure
- Package apb_ram_pkg: state enum (IDLE, ISSUE, RESP), WORD_SHIFT=2, BYTE_LANES=4, DEFAULT_DEPTH_WORDS=2048.
- Single module; no sub-module. The bench instantiates apb_ram_bridge with DFFRAM-style RAM behind it.

## Test plan
- Write PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=4'hF, then read 0x10 -> ram_en pulse one cycle with ram_a=4, ram_we=4'hF; read PREADY at T+2 with PRDATA=0xDEADBEEF, PSLVERR=0.
- Write 0x10 PWDATA=0x11223344 PSTRB=4'b0101 over prior 0xDEADBEEF -> read returns 0xDE22BE44.
- Read PADDR=0x2000 (index 2048) and PADDR=0x13 -> no ram_en, PREADY with PSLVERR=1, PRDATA=0.
- Two back-to-back writes to 0x0 and 0x4 -> PREADY at T+2 and T+5, ram_en high only at T+1 and T+4.
- RST=1 in ISSUE cycle of a write -> next cycle all outputs 0, state IDLE, no RAM write if RST edge precedes ISSUE edge; PSEL drop in ISSUE -> no PREADY pulse.
- PSEL=1, PENABLE=1 while IDLE -> no latch, no ram_en, PREADY stays 0.

Source files
------------

// File: rtl/apb_ram_pkg.sv
// Shared constants and state encoding for the APB-to-RAM bridge.
// Imported by apb_ram_bridge and available to any block that talks to the same RAM.
`timescale 1ns/1ps
package apb_ram_pkg;

  localparam int WORD_SHIFT          = 2;
  localparam int BYTE_LANES          = 4;
  localparam int DEFAULT_DEPTH_WORDS = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/apb_ram_bridge.sv
// APB completer in front of a single-port byte-writable RAM with combinational read data.
// Fixed one-wait-state handshake: setup, RAM access, response; outputs decode from registers only.
`timescale 1ns/1ps
module apb_ram_bridge
  import apb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [BYTE_LANES-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  ram_en,
  output logic [BYTE_LANES-1:0] ram_we,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_a,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_write;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [BYTE_LANES-1:0] r_strb;

  logic                  w_setup;
  logic                  w_addr_err;
  logic                  w_issue_ok;

  assign w_setup = PSEL & ~PENABLE;

  // Full-width compare, so high address bits can never alias into the RAM.
  assign w_addr_err = (|PADDR[WORD_SHIFT-1:0]) |
                      ((PADDR >> WORD_SHIFT) >= ADDR_WIDTH'(DEPTH_WORDS));

  assign w_issue_ok = (r_state == ISSUE) & ~r_err;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_setup) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = PSEL ? RESP : IDLE;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_word_idx <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_strb     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_setup) begin
        r_write    <= PWRITE;
        r_err      <= w_addr_err;
        r_word_idx <= PADDR >> WORD_SHIFT;
        r_wdata    <= PWDATA;
        r_strb     <= PSTRB;
      end
      if (r_state == ISSUE) begin
        r_rdata <= (w_issue_ok && !r_write) ? ram_do : '0;
      end
    end
  end

  // A write with no strobes completes without touching the RAM.
  assign ram_en  = w_issue_ok & (~r_write | (|r_strb));
  assign ram_we  = (w_issue_ok && r_write) ? r_strb : '0;
  assign ram_di  = r_wdata;
  assign ram_a   = r_word_idx;

  assign PREADY  = (r_state == RESP);
  assign PSLVERR = (r_state == RESP) & r_err;
  assign PRDATA  = (r_state == RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_apb_ram_bridge.sv
// Directed bench for apb_ram_bridge with a DFFRAM-style byte-writable RAM behind it.
// Drives APB transfers, logs RAM enables and PREADY cycles, and compares against hand-computed values.
`timescale 1ns/1ps
module tb_apb_ram_bridge;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_a;
  logic [31:0] ram_do;

  apb_ram_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(2048)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PSTRB  (PSTRB),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .ram_en (ram_en),
    .ram_we (ram_we),
    .ram_di (ram_di),
    .ram_a  (ram_a),
    .ram_do (ram_do)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: byte-lane writes on the clock, combinational read.
  logic [31:0] mem [2048];
  initial for (int i = 0; i < 2048; i++) mem[i] <= '0;
  always @(posedge CLK) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_a[10:0]][8*b +: 8] <= ram_di[8*b +: 8];
      end
    end
  end
  assign ram_do = (ram_a < 32'd2048) ? mem[ram_a[10:0]] : '0;

  int          en_q[$];
  int          rdy_q[$];
  logic [31:0] en_a = '0;
  logic [31:0] en_di = '0;
  logic [3:0]  en_we = '0;
  always @(negedge CLK) begin
    if (ram_en) begin
      en_q.push_back(cyc);
      en_a  = ram_a;
      en_we = ram_we;
      en_di = ram_di;
    end
    if (PREADY) rdy_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_logs();
    en_q.delete();
    rdy_q.delete();
  endtask

  // Starts at posedge+1 (setup cycle T) and returns at posedge+1 of T+3 with the bus idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er,
                      output int ts, output int tr);
    logic seen;
    seen = 1'b0;
    rd   = '0;
    er   = 1'b1;
    tr   = -1;
    ts   = cyc;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = st;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin
        @(negedge CLK);
        if (PREADY) begin
          seen = 1'b1;
          rd   = PRDATA;
          er   = PSLVERR;
          tr   = cyc;
        end
      end
    end
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("xfer_ready_seen", 32'(seen), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          ts, tr, ts2, tr2;

  initial begin
    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_pready",  32'(PREADY),  32'd0);
    check("rst_pslverr", 32'(PSLVERR), 32'd0);
    check("rst_prdata",  PRDATA,       32'd0);
    check("rst_ram_en",  32'(ram_en),  32'd0);
    check("rst_ram_we",  32'(ram_we),  32'd0);
    check("rst_ram_di",  ram_di,       32'd0);
    check("rst_ram_a",   ram_a,        32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_cycles(1);

    // Full-word write then read
    clear_logs();
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, ts, tr);
    check("wr_en_count", 32'(en_q.size()), 32'd1);
    check("wr_en_cycle", 32'(q_at(en_q, 0)), 32'(ts + 1));
    check("wr_ram_a",    en_a,  32'd4);
    check("wr_ram_we",   32'(en_we), 32'hF);
    check("wr_ram_di",   en_di, 32'hDEADBEEF);
    check("wr_ready_cyc", 32'(tr), 32'(ts + 2));
    check("wr_err",      32'(er), 32'd0);
    check("wr_prdata",   rd, 32'd0);

    clear_logs();
    xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, er, ts, tr);
    check("rd_data",     rd, 32'hDEADBEEF);
    check("rd_err",      32'(er), 32'd0);
    check("rd_ready_cyc", 32'(tr), 32'(ts + 2));
    check("rd_en_cycle", 32'(q_at(en_q, 0)), 32'(ts + 1));
    check("rd_ram_we",   32'(en_we), 32'd0);

    // Partial strobes: lanes 0 and 2 replaced
    xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er, ts, tr);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, ts, tr);
    check("strb_merge", rd, 32'hDE22BE44);

    // Error responses: out of range, misaligned, high-bit alias, misaligned write
    clear_logs();
    xfer(1'b0, 32'h2000, 32'h0, 4'h0, rd, er, ts, tr);
    check("oor_err",    32'(er), 32'd1);
    check("oor_prdata", rd, 32'd0);
    check("oor_ready_cyc", 32'(tr), 32'(ts + 2));
    xfer(1'b0, 32'h13, 32'h0, 4'h0, rd, er, ts, tr);
    check("mis_err",    32'(er), 32'd1);
    check("mis_prdata", rd, 32'd0);
    xfer(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, ts, tr);
    check("alias_err",  32'(er), 32'd1);
    xfer(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, er, ts, tr);
    check("mis_wr_err", 32'(er), 32'd1);
    check("err_no_en",  32'(en_q.size()), 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, ts, tr);
    check("err_no_corrupt", rd, 32'hDE22BE44);

    // Last valid word
    xfer(1'b1, 32'h1FFC, 32'hA5A55A5A, 4'hF, rd, er, ts, tr);
    check("top_wr_err", 32'(er), 32'd0);
    xfer(1'b0, 32'h1FFC, 32'h0, 4'h0, rd, er, ts, tr);
    check("top_rd_data", rd, 32'hA5A55A5A);
    check("top_rd_err",  32'(er), 32'd0);

    // Zero-strobe write: OKAY without RAM access
    clear_logs();
    xfer(1'b1, 32'h10, 32'h0, 4'h0, rd, er, ts, tr);
    check("z_strb_en",  32'(en_q.size()), 32'd0);
    check("z_strb_err", 32'(er), 32'd0);
    check("z_strb_rdy", 32'(tr), 32'(ts + 2));
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, ts, tr);
    check("z_strb_keep", rd, 32'hDE22BE44);

    // Back-to-back writes
    idle_cycles(1);
    clear_logs();
    xfer(1'b1, 32'h0, 32'h00001111, 4'hF, rd, er, ts, tr);
    xfer(1'b1, 32'h4, 32'h22220000, 4'hF, rd, er, ts2, tr2);
    check("b2b_setup2", 32'(ts2), 32'(ts + 3));
    check("b2b_rdy1",   32'(tr),  32'(ts + 2));
    check("b2b_rdy2",   32'(tr2), 32'(ts + 5));
    check("b2b_en_n",   32'(en_q.size()), 32'd2);
    check("b2b_en0",    32'(q_at(en_q, 0)), 32'(ts + 1));
    check("b2b_en1",    32'(q_at(en_q, 1)), 32'(ts + 4));
    check("b2b_rdy_n",  32'(rdy_q.size()), 32'd2);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, ts, tr);
    check("b2b_rd0", rd, 32'h00001111);
    xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, ts, tr);
    check("b2b_rd1", rd, 32'h22220000);

    // Reset during setup: nothing reaches the RAM
    clear_logs();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h24; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; PSEL = 1'b0; PWRITE = 1'b0;
    idle_cycles(3);
    check("rst_setup_en",  32'(en_q.size()), 32'd0);
    check("rst_setup_rdy", 32'(rdy_q.size()), 32'd0);
    xfer(1'b0, 32'h24, 32'h0, 4'h0, rd, er, ts, tr);
    check("rst_setup_mem", rd, 32'd0);

    // Reset during ISSUE: outputs cleared next cycle, no response
    clear_logs();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h28; PWDATA = 32'h12345678; PSTRB = 4'hF;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge CLK);
    check("rst_iss_pready",  32'(PREADY),  32'd0);
    check("rst_iss_pslverr", 32'(PSLVERR), 32'd0);
    check("rst_iss_prdata",  PRDATA,       32'd0);
    check("rst_iss_en",      32'(ram_en),  32'd0);
    check("rst_iss_we",      32'(ram_we),  32'd0);
    check("rst_iss_di",      ram_di,       32'd0);
    check("rst_iss_a",       ram_a,        32'd0);
    idle_cycles(3);
    check("rst_iss_rdy_n", 32'(rdy_q.size()), 32'd0);

    // PSEL dropped in ISSUE: no PREADY, bridge usable afterwards
    clear_logs();
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h10;
    @(posedge CLK); #1;
    PSEL = 1'b0;
    idle_cycles(3);
    check("abort_rdy_n", 32'(rdy_q.size()), 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, ts, tr);
    check("abort_recover_data", rd, 32'hDE22BE44);
    check("abort_recover_rdy",  32'(tr), 32'(ts + 2));

    // PSEL & PENABLE while IDLE: ignored
    clear_logs();
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
    idle_cycles(3);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    idle_cycles(1);
    check("viol_en_n",  32'(en_q.size()), 32'd0);
    check("viol_rdy_n", 32'(rdy_q.size()), 32'd0);
    xfer(1'b0, 32'h30, 32'h0, 4'h0, rd, er, ts, tr);
    check("viol_mem", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
